// File: rtl/i2s_tx_serializer_if.sv
// rtl/i2s_tx_serializer_if.sv - sample handshake bundle feeding the I2S transmit serializer
interface i2s_tx_serializer_if #(
    parameter int SAMPLE_BITS = 16
);
    logic                       sample_valid;
    logic [2*SAMPLE_BITS-1:0]   sample_data;
    logic                       sample_ready;

    modport master (
        output sample_valid,
        output sample_data,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        output sample_ready
    );
endinterface

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - stereo word to I2S serializer with BCLK/LRCLK generation (I2S_LJ_FORMAT_EN selects left-justified)
module i2s_tx_serializer #(
    parameter int SAMPLE_BITS = 16,
    parameter int SLOT_BITS   = 32,
    parameter int BCLK_DIV    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_enable,
    i2s_tx_serializer_if.slave      smp,
    input  logic                    mute,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    frame_start,
    output logic                    underrun
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int B_W        = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME_BITS - 1);
    localparam logic [B_W-1:0]   B_SLOT   = B_W'(SLOT_BITS);

    logic [DIV_W-1:0]           div_cnt;
    logic [B_W-1:0]             bit_idx;
    logic [B_W-1:0]             bit_next;
    logic [FRAME_BITS-1:0]      shift_q;
    logic [FRAME_BITS-1:0]      shift_next;
    logic [FRAME_BITS-1:0]      load_word;
    logic                       hold_full;
    logic [2*SAMPLE_BITS-1:0]   hold_data;

    logic                       div_term;
    logic                       fall_evt;
    logic                       load_evt;
    logic                       accept;

    // The holding register is the only buffer, so ready is simply "it is empty".
    assign smp.sample_ready = !hold_full;

    // Event decode: every serial-side update happens on a bclk falling toggle.
    always_comb begin
        div_term = clk_enable && (div_cnt == DIV_LAST);
        fall_evt = div_term && bclk;
        load_evt = fall_evt && (bit_idx == B_LAST);
        accept   = smp.sample_valid && !hold_full && clk_enable;
        bit_next = (bit_idx == B_LAST) ? '0 : bit_idx + 1'b1;
    end

    // Frame image: left sample MSB-aligned in the upper slot, right in the lower; muted or empty sends zeros.
    always_comb begin
        load_word = '0;
        if (hold_full && !mute) begin
            load_word[FRAME_BITS-1 -: SAMPLE_BITS] = hold_data[SAMPLE_BITS-1:0];
            load_word[SLOT_BITS-1  -: SAMPLE_BITS] = hold_data[2*SAMPLE_BITS-1:SAMPLE_BITS];
        end
        shift_next = load_evt ? load_word : {shift_q[FRAME_BITS-2:0], 1'b0};
    end

    // Bit clock divider: toggle bclk every BCLK_DIV enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (clk_enable) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                bclk    <= !bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Serial side: bit index, shift register, word clock and data all advance on fall events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx <= B_LAST;
            shift_q <= '0;
            lrclk   <= 1'b0;
            sdata   <= 1'b0;
        end else if (fall_evt) begin
            bit_idx <= bit_next;
            shift_q <= shift_next;
            lrclk   <= (bit_next >= B_SLOT);
`ifdef I2S_LJ_FORMAT_EN
            sdata   <= shift_next[FRAME_BITS-1];
`else
            sdata   <= shift_q[FRAME_BITS-1];
`endif
        end
    end

    // One-cycle status pulses at each frame load; load_evt already implies clk_enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= load_evt;
            underrun    <= load_evt && !hold_full;
        end
    end

    // Holding register: accept wins, which only matters when a word lands on a load with hold empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= smp.sample_data;
        end else if (load_evt) begin
            hold_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - directed self-checking bench for i2s_tx_serializer
module tb_i2s_tx_serializer;

    localparam int SB = 16;
    localparam int SL = 32;
    localparam int BD = 2;

    logic clk = 1'b0;
    logic rst;
    logic clk_enable;
    logic mute;
    logic bclk, lrclk, sdata, frame_start, underrun;

    i2s_tx_serializer_if #(.SAMPLE_BITS(SB)) smp ();

    i2s_tx_serializer #(
        .SAMPLE_BITS(SB),
        .SLOT_BITS  (SL),
        .BCLK_DIV   (BD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .smp        (smp),
        .mute       (mute),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          fs_seen = 0;
    int          ur_seen = 0;
    int          n_falls = 0;
    logic        prev_bclk = 1'b0;
    logic        fell = 1'b0;
    logic [31:0] feed[$];

    localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: handshake bookkeeping, then sample at the negedge.
    task automatic clk_step();
        logic acc;
        acc = smp.sample_valid && smp.sample_ready && clk_enable;
        prev_bclk = bclk;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (acc) void'(feed.pop_front());
        smp.sample_valid = (feed.size() != 0);
        smp.sample_data  = (feed.size() != 0) ? feed[0] : 32'h0;
        fell = prev_bclk && !bclk;
        if (fell) n_falls++;
        if (frame_start) fs_seen++;
        if (underrun) ur_seen++;
    endtask

    task automatic push_word(input logic [31:0] w);
        feed.push_back(w);
        smp.sample_valid = 1'b1;
        smp.sample_data  = feed[0];
    endtask

    task automatic wait_load(input string tag, output int clks);
        clks = 0;
        do begin
            clk_step();
            clks++;
        end while (!frame_start && clks < 400);
        check({tag, " load seen"}, 64'(frame_start), 64'd1);
    endtask

    // Called at the negedge right after a load; records sdata/lrclk for b = 0..63.
    task automatic capture(input int freeze_b, output logic [63:0] bits, output logic [63:0] lr);
        int guard;
        int falls0;
        logic fb, fl, fd;
        bits = '0;
        lr = '0;
        bits[0] = sdata;
        lr[0] = lrclk;
        fs_seen = 0;
        falls0 = n_falls;
        for (int b = 1; b < 64; b++) begin
            if (b == freeze_b) begin
                fb = bclk; fl = lrclk; fd = sdata;
                clk_enable = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    clk_step();
                    check("freeze levels", 64'({bclk, lrclk, sdata}), 64'({fb, fl, fd}));
                end
                check("freeze pulses", 64'(fs_seen), 64'd0);
                clk_enable = 1'b1;
            end
            guard = 0;
            do begin
                clk_step();
                guard++;
            end while (!fell && guard < 20);
            bits[b] = sdata;
            lr[b] = lrclk;
        end
        check("falls per frame", 64'(n_falls - falls0), 64'd63);
        check("no extra frame_start", 64'(fs_seen), 64'd0);
    endtask

    function automatic logic [63:0] exp_bits(input logic [31:0] w);
        logic [63:0] e;
        e = '0;
        for (int i = 0; i < 16; i++) begin
`ifdef I2S_LJ_FORMAT_EN
            e[i]      = w[15-i];
            e[32 + i] = w[31-i];
`else
            e[1 + i]  = w[15-i];
            e[33 + i] = w[31-i];
`endif
        end
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] bits, lr;
        int clks, last_load, guard;

        rst = 1'b1;
        clk_enable = 1'b1;
        mute = 1'b0;
        smp.sample_valid = 1'b0;
        smp.sample_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst bclk", 64'(bclk), 64'd0);
        check("rst lrclk", 64'(lrclk), 64'd0);
        check("rst sdata", 64'(sdata), 64'd0);
        check("rst pulses", 64'({frame_start, underrun}), 64'd0);
        check("rst ready", 64'(smp.sample_ready), 64'd1);

        // Divider timing and first underrun load
        rst = 1'b0;
        clk_step(); check("clk1 bclk", 64'(bclk), 64'd0);
        clk_step(); check("clk2 bclk", 64'(bclk), 64'd1);
        clk_step(); check("clk3 bclk", 64'(bclk), 64'd1);
        check("clk3 frame_start", 64'(frame_start), 64'd0);
        clk_step(); check("clk4 bclk", 64'(bclk), 64'd0);
        check("clk4 frame_start", 64'(frame_start), 64'd1);
        check("clk4 underrun", 64'(underrun), 64'd1);
        check("clk4 lrclk", 64'(lrclk), 64'd0);
        last_load = cyc;
        capture(-1, bits, lr);
        check("idle frame sdata", bits, 64'd0);
        check("idle frame lrclk", lr, LR_EXP);

        // Single word before the next load
        push_word(32'h8001_A5A5);
        clk_step();
        check("accept ready low", 64'(smp.sample_ready), 64'd0);
        check("accept consumed", 64'(feed.size()), 64'd0);
        wait_load("t2", clks);
        check("frame period", 64'(cyc - last_load), 64'd256);
        check("t2 underrun", 64'(underrun), 64'd0);
        capture(-1, bits, lr);
`ifdef I2S_LJ_FORMAT_EN
        check("lj word bits", bits, 64'h0000_8001_0000_A5A5);
`else
        check("i2s word bits", bits, 64'h0001_0002_0001_4B4A);
`endif
        check("word lrclk", lr, LR_EXP);

        // valid held high across three words
        feed.push_back(32'h1234_C3F0);
        feed.push_back(32'hFFFF_0001);
        push_word(32'h7E5A_0F81);
        wait_load("w0", clks);
        check("w0 underrun", 64'(underrun), 64'd0);
        check("ready after load", 64'(smp.sample_ready), 64'd1);
        check("only w0 taken", 64'(feed.size()), 64'd2);
        capture(-1, bits, lr);
        check("w1 taken after load", 64'(feed.size()), 64'd1);
        check("w0 bits", bits, exp_bits(32'h1234_C3F0));

        wait_load("w1", clks);
        check("w1 underrun", 64'(underrun), 64'd0);
        capture(10, bits, lr);
        check("w1 bits with freeze", bits, exp_bits(32'hFFFF_0001));
        check("w1 lrclk with freeze", lr, LR_EXP);

        wait_load("w2", clks);
        check("w2 underrun", 64'(underrun), 64'd0);
        capture(-1, bits, lr);
        check("w2 bits", bits, exp_bits(32'h7E5A_0F81));
        check("queue drained", 64'(feed.size()), 64'd0);

        // Mute at a load with hold full
        push_word(32'hDEAD_BEEF);
        mute = 1'b1;
        wait_load("mute", clks);
        mute = 1'b0;
        check("mute underrun", 64'(underrun), 64'd0);
        capture(-1, bits, lr);
        check("mute bits", bits, 64'd0);
        wait_load("after mute", clks);
        check("hold consumed by mute", 64'(underrun), 64'd1);

        // Reset mid-frame at b=20 with hold full
        push_word(32'h5555_AAAA);
        clk_step();
        check("hold full before rst", 64'(smp.sample_ready), 64'd0);
        guard = 0;
        n_falls = 0;
        while (n_falls < 19 && guard < 200) begin
            clk_step();
            guard++;
        end
        check("reached b20", 64'(n_falls), 64'd19);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid rst bclk", 64'(bclk), 64'd0);
        check("mid rst lrclk/sdata", 64'({lrclk, sdata}), 64'd0);
        check("mid rst ready", 64'(smp.sample_ready), 64'd1);
        check("mid rst pulses", 64'({frame_start, underrun}), 64'd0);
        rst = 1'b0;
        clk_step();
        clk_step(); check("post rst clk2 bclk", 64'(bclk), 64'd1);
        clk_step(); check("post rst clk3 pulse", 64'(frame_start), 64'd0);
        clk_step();
        check("post rst clk4 frame_start", 64'(frame_start), 64'd1);
        check("post rst clk4 underrun", 64'(underrun), 64'd1);
        capture(-1, bits, lr);
        check("post rst frame zeros", bits, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
